// File: rtl/lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lock_ctrl: four-digit code lock with timed open window and lockout.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module lock_ctrl #(
  parameter logic [15:0] CODE        = 16'h1234,
  parameter int          OPEN_CYCLES = 50,
  parameter int          LOCK_CYCLES = 200,
  parameter int          MAX_FAIL    = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] digit,
  input  logic       enter,
  input  logic       cancel,
  output logic       unlock,
  output logic       alarm,
  output logic [1:0] pos,
  output logic       err,
  output logic       digit_clr
);

  localparam int TMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
  localparam int TW   = (TMAX < 2) ? 1 : $clog2(TMAX + 1);

  localparam logic [TW-1:0] C_OPEN_LOAD = TW'(OPEN_CYCLES - 1);
  localparam logic [TW-1:0] C_LOCK_LOAD = TW'(LOCK_CYCLES - 1);
  localparam logic [TW-1:0] C_T_ZERO    = '0;
  localparam logic [TW-1:0] C_T_ONE     = TW'(1);
  localparam logic [2:0]    C_FAIL_LIM  = 3'(MAX_FAIL);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_COLLECT = 3'd1;
  localparam logic [2:0] S_CHECK   = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_LOCKOUT = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [1:0]    pos_q, pos_d;
  logic [15:0]   code_q, code_d;
  logic [2:0]    fail_q, fail_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          unlock_q, unlock_d;
  logic          alarm_q, alarm_d;
  logic          err_q, err_d;
  logic          digit_clr_q, digit_clr_d;
  logic          clr_req;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q     <= S_IDLE;
      pos_q       <= 2'd0;
      code_q      <= 16'h0000;
      fail_q      <= 3'd0;
      timer_q     <= C_T_ZERO;
      unlock_q    <= 1'b0;
      alarm_q     <= 1'b0;
      err_q       <= 1'b0;
      digit_clr_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      code_q      <= code_d;
      fail_q      <= fail_d;
      timer_q     <= timer_d;
      unlock_q    <= unlock_d;
      alarm_q     <= alarm_d;
      err_q       <= err_d;
      digit_clr_q <= digit_clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    code_d  = code_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    clr_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enter && !cancel) begin
          code_d[15:12] = digit;
          pos_d         = 2'd1;
          state_d       = S_COLLECT;
          clr_req       = 1'b1;
        end
      end
      S_COLLECT: begin
        if (cancel) begin
          pos_d   = 2'd0;
          state_d = S_IDLE;
          clr_req = 1'b1;
        end else if (enter) begin
          case (pos_q)
            2'd1:    code_d[11:8] = digit;
            2'd2:    code_d[7:4]  = digit;
            default: code_d[3:0]  = digit;
          endcase
          pos_d   = pos_q + 2'd1;
          clr_req = 1'b1;
          if (pos_q == 2'd3) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (code_q == CODE) begin
          state_d = S_OPEN;
          fail_d  = 3'd0;
          timer_d = C_OPEN_LOAD;
        end else begin
          fail_d = fail_q + 3'd1;
          if (fail_d == C_FAIL_LIM) begin
            state_d = S_LOCKOUT;
            timer_d = C_LOCK_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (timer_q == C_T_ZERO) state_d = S_IDLE;
        else                     timer_d = timer_q - C_T_ONE;
      end
      S_LOCKOUT: begin
        if (timer_q == C_T_ZERO) begin
          state_d = S_IDLE;
          fail_d  = 3'd0;
        end else begin
          timer_d = timer_q - C_T_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    unlock_d    = (state_d == S_OPEN);
    alarm_d     = (state_d == S_LOCKOUT);
    err_d       = (state_d == S_CHECK) && (code_d != CODE);
    digit_clr_d = clr_req;
  end

  assign unlock    = unlock_q;
  assign alarm     = alarm_q;
  assign pos       = pos_q;
  assign err       = err_q;
  assign digit_clr = digit_clr_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lock_ctrl: directed bench with pulse-length scoreboard for lock_ctrl. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_lock_ctrl;

  logic       clk = 1'b0;
  logic       clr;
  logic [3:0] digit;
  logic       enter;
  logic       cancel;
  logic       unlock, alarm, err, digit_clr;
  logic [1:0] pos;

  int total = 0;
  int bad   = 0;

  localparam int K_ERR    = 0;
  localparam int K_UNLOCK = 1;
  localparam int K_ALARM  = 2;

  typedef struct {
    int kind;
    int len;
  } ev_t;
  ev_t sb[$];
  int  run[3] = '{0, 0, 0};

  lock_ctrl dut (
    .clk       (clk),
    .clr       (clr),
    .digit     (digit),
    .enter     (enter),
    .cancel    (cancel),
    .unlock    (unlock),
    .alarm     (alarm),
    .pos       (pos),
    .err       (err),
    .digit_clr (digit_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic push(input int kind, input int len);
    ev_t e;
    e.kind = kind;
    e.len  = len;
    sb.push_back(e);
  endtask

  // Each output pulse is measured in cycles and matched against the queue on its falling edge.
  always @(negedge clk) begin
    logic v;
    ev_t  e;
    for (int k = 0; k < 3; k++) begin
      v = (k == K_ERR) ? err : ((k == K_UNLOCK) ? unlock : alarm);
      if (v === 1'b1) begin
        run[k]++;
      end else if (run[k] > 0) begin
        if (sb.size() == 0) begin
          e.kind = -1;
          e.len  = 0;
        end else begin
          e = sb.pop_front();
        end
        chk("pulse_kind", k, e.kind);
        chk("pulse_len", run[k], e.len);
        run[k] = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [3:0] d);
    digit = d;
    enter = 1'b1;
    tick();
    enter = 1'b0;
  endtask

  task automatic enter_code(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                            input logic [3:0] d, input logic exp_err, input string tag);
    press(a);
    chk({tag, "_pos1"}, pos, 1);
    chk({tag, "_dclr"}, digit_clr, 1);
    press(b);
    chk({tag, "_pos2"}, pos, 2);
    press(c);
    chk({tag, "_pos3"}, pos, 3);
    press(d);
    chk({tag, "_pos0"}, pos, 0);
    chk({tag, "_err"}, err, exp_err);
    chk({tag, "_unlock_chk"}, unlock, 0);
  endtask

  task automatic wait_open(input string tag);
    tick();
    chk({tag, "_unlock_on"}, unlock, 1);
    for (int i = 0; i < 200 && unlock === 1'b1; i++) tick();
    chk({tag, "_unlock_off"}, unlock, 0);
    chk({tag, "_pos_idle"}, pos, 0);
    tick();
  endtask

  initial begin
    clr    = 1'b0;
    digit  = 4'd0;
    enter  = 1'b0;
    cancel = 1'b0;
    tick();
    tick();
    chk("rst_unlock", unlock, 0);
    chk("rst_alarm", alarm, 0);
    chk("rst_err", err, 0);
    chk("rst_pos", pos, 0);
    chk("rst_dclr", digit_clr, 1);
    clr = 1'b1;
    tick();
    chk("post_rst_dclr", digit_clr, 0);

    // Correct code
    push(K_UNLOCK, 50);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "good");
    wait_open("good");
    chk("good_fail", dut.fail_q, 0);

    // Wrong code
    push(K_ERR, 1);
    enter_code(4'd1, 4'd2, 4'd3, 4'd5, 1'b1, "wrong");
    tick();
    chk("wrong_err_off", err, 0);
    chk("wrong_fail", dut.fail_q, 1);
    chk("wrong_unlock", unlock, 0);

    // Two more wrong codes reach lockout; digit > 9 can never match
    push(K_ERR, 1);
    enter_code(4'd9, 4'd9, 4'd9, 4'd9, 1'b1, "wrong2");
    tick();
    push(K_ERR, 1);
    push(K_ALARM, 200);
    enter_code(4'd1, 4'd2, 4'd3, 4'hC, 1'b1, "wrong3");
    tick();
    chk("lock_alarm_on", alarm, 1);
    press(4'd1);
    chk("lock_enter_pos", pos, 0);
    chk("lock_enter_dclr", digit_clr, 0);
    press(4'd2);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("lock_pos_still0", pos, 0);
    for (int i = 0; i < 300 && alarm === 1'b1; i++) tick();
    chk("lock_alarm_off", alarm, 0);
    chk("lock_fail_clr", dut.fail_q, 0);
    push(K_UNLOCK, 50);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "after_lock");
    wait_open("after_lock");

    // Cancel mid-entry
    press(4'd1);
    press(4'd2);
    tick();
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    chk("cancel_pos", pos, 0);
    chk("cancel_dclr", digit_clr, 1);
    tick();
    chk("cancel_dclr_off", digit_clr, 0);
    push(K_UNLOCK, 50);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "after_cancel");
    wait_open("after_cancel");
    chk("cancel_fail", dut.fail_q, 0);

    // Enter and cancel together: cancel wins
    press(4'd1);
    digit  = 4'd2;
    enter  = 1'b1;
    cancel = 1'b1;
    tick();
    enter  = 1'b0;
    cancel = 1'b0;
    chk("simul_pos", pos, 0);
    push(K_UNLOCK, 50);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "after_simul");
    wait_open("after_simul");

    // Fail counter cleared by a correct code
    push(K_ERR, 1);
    enter_code(4'd5, 4'd5, 4'd5, 4'd5, 1'b1, "fr1");
    tick();
    push(K_ERR, 1);
    enter_code(4'd0, 4'd0, 4'd0, 4'd0, 1'b1, "fr2");
    tick();
    chk("fr_fail2", dut.fail_q, 2);
    push(K_UNLOCK, 50);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "fr_good");
    wait_open("fr_good");
    chk("fr_fail_clr", dut.fail_q, 0);
    push(K_ERR, 1);
    enter_code(4'd4, 4'd3, 4'd2, 4'd1, 1'b1, "fr3");
    tick();
    chk("fr_no_alarm", alarm, 0);
    chk("fr_fail1", dut.fail_q, 1);

    // Reset during OPEN at cycle 10
    push(K_UNLOCK, 10);
    enter_code(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, "mid");
    for (int i = 0; i < 10; i++) tick();
    chk("mid_unlock_on", unlock, 1);
    clr = 1'b0;
    tick();
    chk("mid_unlock_off", unlock, 0);
    chk("mid_dclr", digit_clr, 1);
    chk("mid_pos", pos, 0);
    chk("mid_alarm", alarm, 0);
    clr = 1'b1;
    tick();
    chk("mid_dclr_off", digit_clr, 0);
    chk("mid_fail", dut.fail_q, 0);
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
